mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_load_rob.sv | 110 +++++++++++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: bus widths, memory command
// encoding, grant direction and the default load table depth.
package mem_port_arbiter_pkg;

    localparam int RD_DEPTH_DEFAULT = 4;

    localparam int ADDR_W  = 32;
    localparam int BLOCK_W = 64;
    localparam int TAG_W   = 4;

    typedef logic [ADDR_W-1:0]  ADDR;
    typedef logic [BLOCK_W-1:0] MEM_BLOCK;
    typedef logic [TAG_W-1:0]   MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_load_rob.sv
// In-order table of outstanding loads. Entries are allocated at the tail
// with the memory's transaction tag, filled out of order by returning data
// tags, and released strictly from the head so responses keep issue order.
module mem_load_rob
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = RD_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc,
    input  MEM_TAG                 alloc_tag,
    input  MEM_TAG                 fill_tag,
    input  MEM_BLOCK               fill_data,
    input  logic                   rsp_rdy,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   rsp_vld,
    output MEM_BLOCK               rsp_data,
    output logic                   err_unmatched
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    MEM_TAG           tag_q  [DEPTH];
    MEM_BLOCK         data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [DEPTH-1:0] filled_d;
    logic [DEPTH-1:0] fill_hit;
    logic [PTR_W-1:0] head_q, head_d, tail_q, idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic             err_q;
    logic             found;
    logic             fill_miss;
    logic             pop;

    assign pop           = rsp_vld_q && rsp_rdy;
    assign full          = (count_q == CNT_W'(DEPTH));
    assign count         = count_q;
    assign rsp_vld       = rsp_vld_q;
    assign rsp_data      = data_q[head_q];
    assign err_unmatched = err_q;
    assign fill_miss     = (fill_tag != '0) && !found;

    // Walk entries oldest-first and pick the first unfilled one whose tag matches.
    always_comb begin
        fill_hit = '0;
        found    = 1'b0;
        idx      = head_q;
        if (fill_tag != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_q + PTR_W'(k);
                if (!found && (CNT_W'(k) < count_q) && !filled_q[idx] && (tag_q[idx] == fill_tag)) begin
                    fill_hit[idx] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end

    // Next-state of head, count and fill flags so the response valid can be registered.
    always_comb begin
        filled_d = filled_q | fill_hit;
        if (pop) begin
            filled_d[head_q] = 1'b0;
        end
        if (alloc) begin
            filled_d[tail_q] = 1'b0;
        end
        head_d    = pop ? head_q + PTR_W'(1) : head_q;
        count_d   = count_q + CNT_W'(alloc) - CNT_W'(pop);
        rsp_vld_d = (count_d != '0) && filled_d[head_d];
    end

    // Table state registers; reset drops every outstanding load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            filled_q  <= '0;
            rsp_vld_q <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= alloc ? tail_q + PTR_W'(1) : tail_q;
            count_q   <= count_d;
            filled_q  <= filled_d;
            rsp_vld_q <= rsp_vld_d;
            if (fill_miss) begin
                err_q <= 1'b1;
            end
            if (alloc) begin
                tag_q[tail_q] <= alloc_tag;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (fill_hit[i]) begin
                    data_q[i] <= fill_data;
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one load and one store requester onto a single tagged memory
// port, alternating on ties, and returns load data in issue order.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_DEPTH = RD_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req_vld,
    input  ADDR        rd_req_addr,
    output logic       rd_req_rdy,
    input  logic       wr_req_vld,
    input  ADDR        wr_req_addr,
    input  MEM_BLOCK   wr_req_data,
    output logic       wr_req_rdy,
    output logic       rd_rsp_vld,
    output MEM_BLOCK   rd_rsp_data,
    input  logic       rd_rsp_rdy,
    output MEM_COMMAND proc2mem_command,
    output ADDR        proc2mem_addr,
    output MEM_BLOCK   proc2mem_data,
    input  MEM_TAG     mem2proc_transaction_tag,
    input  MEM_BLOCK   mem2proc_data,
    input  MEM_TAG     mem2proc_data_tag,
    output logic       idle,
    output logic       err_unmatched
);

    localparam int CNT_W = $clog2(RD_DEPTH) + 1;

    grant_e           last_grant;
    logic             rd_full;
    logic [CNT_W-1:0] rd_count;
    logic             rd_elig, wr_elig;
    logic             gnt_rd, gnt_wr;
    logic             cmd_accepted;

    assign rd_elig      = rst && rd_req_vld && !rd_full;
    assign wr_elig      = rst && wr_req_vld;
    assign cmd_accepted = (mem2proc_transaction_tag != '0);
    assign rd_req_rdy   = gnt_rd && cmd_accepted;
    assign wr_req_rdy   = gnt_wr && cmd_accepted;
    assign idle         = (rd_count == '0) && !rd_req_vld && !wr_req_vld;

    // Grant the lone eligible side, or the side not granted last on a tie.
    always_comb begin
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (rd_elig && wr_elig) begin
            if (last_grant == GNT_WR) begin
                gnt_rd = 1'b1;
            end else begin
                gnt_wr = 1'b1;
            end
        end else begin
            gnt_rd = rd_elig;
            gnt_wr = wr_elig;
        end
    end

    // Drive the memory command for the granted side, zeros when idle.
    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (gnt_rd) begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = rd_req_addr;
        end else if (gnt_wr) begin
            proc2mem_command = MEM_STORE;
            proc2mem_addr    = wr_req_addr;
            proc2mem_data    = wr_req_data;
        end
    end

    // Remember who won, but only once memory actually took the command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GNT_WR;
        end else if (cmd_accepted && gnt_rd) begin
            last_grant <= GNT_RD;
        end else if (cmd_accepted && gnt_wr) begin
            last_grant <= GNT_WR;
        end
    end

    mem_load_rob #(
        .DEPTH (RD_DEPTH)
    ) u_rob (
        .clk           (clk),
        .rst           (rst),
        .alloc         (rd_req_rdy),
        .alloc_tag     (mem2proc_transaction_tag),
        .fill_tag      (mem2proc_data_tag),
        .fill_data     (mem2proc_data),
        .rsp_rdy       (rd_rsp_rdy),
        .full          (rd_full),
        .count         (rd_count),
        .rsp_vld       (rd_rsp_vld),
        .rsp_data      (rd_rsp_data),
        .err_unmatched (err_unmatched)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for arbitration and
// command muxing, then hand-timed sequences for the load table corners.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam ADDR      RD_ADDR = 32'h0000_1000;
    localparam ADDR      WR_ADDR = 32'h0000_2000;
    localparam MEM_BLOCK WR_DATA = 64'hDEAD_BEEF_0000_1111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_req_vld = 1'b0;
    ADDR        rd_req_addr = RD_ADDR;
    logic       rd_req_rdy;
    logic       wr_req_vld = 1'b0;
    ADDR        wr_req_addr = WR_ADDR;
    MEM_BLOCK   wr_req_data = WR_DATA;
    logic       wr_req_rdy;
    logic       rd_rsp_vld;
    MEM_BLOCK   rd_rsp_data;
    logic       rd_rsp_rdy = 1'b1;
    MEM_COMMAND proc2mem_command;
    ADDR        proc2mem_addr;
    MEM_BLOCK   proc2mem_data;
    MEM_TAG     mem2proc_transaction_tag = '0;
    MEM_BLOCK   mem2proc_data = '0;
    MEM_TAG     mem2proc_data_tag = '0;
    logic       idle;
    logic       err_unmatched;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic       rd_vld;
        logic       wr_vld;
        MEM_TAG     txn_tag;
        MEM_COMMAND exp_cmd;
        logic       exp_rd_rdy;
        logic       exp_wr_rdy;
        logic       exp_idle;
    } arb_vec_t;

    arb_vec_t vecs [13];

    mem_port_arbiter #(.RD_DEPTH(4)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .rd_req_vld               (rd_req_vld),
        .rd_req_addr              (rd_req_addr),
        .rd_req_rdy               (rd_req_rdy),
        .wr_req_vld               (wr_req_vld),
        .wr_req_addr              (wr_req_addr),
        .wr_req_data              (wr_req_data),
        .wr_req_rdy               (wr_req_rdy),
        .rd_rsp_vld               (rd_rsp_vld),
        .rd_rsp_data              (rd_rsp_data),
        .rd_rsp_rdy               (rd_rsp_rdy),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .proc2mem_data            (proc2mem_data),
        .mem2proc_transaction_tag (mem2proc_transaction_tag),
        .mem2proc_data            (mem2proc_data),
        .mem2proc_data_tag        (mem2proc_data_tag),
        .idle                     (idle),
        .err_unmatched            (err_unmatched)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Advance one cycle, drive inputs just after the edge, settle before returning.
    task automatic applyStimulus(input logic rv, input logic wv, input MEM_TAG tt,
                                 input MEM_TAG dt, input MEM_BLOCK dd);
        @(posedge clk);
        #1;
        rd_req_vld               = rv;
        wr_req_vld               = wv;
        mem2proc_transaction_tag = tt;
        mem2proc_data_tag        = dt;
        mem2proc_data            = dd;
        #3;
    endtask

    task automatic doReset();
        rst                      = 1'b0;
        rd_req_vld               = 1'b0;
        wr_req_vld               = 1'b0;
        mem2proc_transaction_tag = '0;
        mem2proc_data_tag        = '0;
        mem2proc_data            = '0;
        rd_rsp_rdy               = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic checkCommand(input string name, input MEM_COMMAND exp_cmd);
        ADDR      exp_addr;
        MEM_BLOCK exp_data;
        exp_addr = '0;
        exp_data = '0;
        if (exp_cmd == MEM_LOAD) begin
            exp_addr = RD_ADDR;
        end else if (exp_cmd == MEM_STORE) begin
            exp_addr = WR_ADDR;
            exp_data = WR_DATA;
        end
        checkOutput({name, ".cmd"},  64'(proc2mem_command), 64'(exp_cmd));
        checkOutput({name, ".addr"}, 64'(proc2mem_addr),    64'(exp_addr));
        checkOutput({name, ".data"}, proc2mem_data,         exp_data);
    endtask

    initial begin
        // Arbitration table, starting from reset with last_grant = WR.
        vecs[0]  = '{1'b0, 1'b0, 4'd1, MEM_NONE,  1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 4'd1, MEM_LOAD,  1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'd2, MEM_STORE, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4'd0, MEM_LOAD,  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 4'd3, MEM_LOAD,  1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'd5, MEM_NONE,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'd5, MEM_STORE, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'd4, MEM_LOAD,  1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 4'd6, MEM_STORE, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'd7, MEM_LOAD,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'd8, MEM_NONE,  1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 4'd9, MEM_STORE, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 4'd9, MEM_STORE, 1'b0, 1'b1, 1'b0};

        // Values held while reset is asserted.
        #7;
        checkOutput("reset.cmd",     64'(proc2mem_command), 64'(MEM_NONE));
        checkOutput("reset.idle",    64'(idle),             64'd1);
        checkOutput("reset.rsp_vld", 64'(rd_rsp_vld),       64'd0);
        checkOutput("reset.err",     64'(err_unmatched),    64'd0);
        rd_req_vld = 1'b1;
        wr_req_vld = 1'b1;
        mem2proc_transaction_tag = 4'd1;
        #1;
        checkOutput("reset.cmd_vld", 64'(proc2mem_command), 64'(MEM_NONE));
        checkOutput("reset.rd_rdy",  64'(rd_req_rdy),       64'd0);
        checkOutput("reset.wr_rdy",  64'(wr_req_rdy),       64'd0);
        checkOutput("reset.addr",    64'(proc2mem_addr),    64'd0);
        doReset();

        // Table-driven arbitration vectors.
        for (int i = 0; i < 13; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].rd_vld, vecs[i].wr_vld, vecs[i].txn_tag, '0, '0);
            checkCommand(nm, vecs[i].exp_cmd);
            checkOutput({nm, ".rd_rdy"}, 64'(rd_req_rdy), 64'(vecs[i].exp_rd_rdy));
            checkOutput({nm, ".wr_rdy"}, 64'(wr_req_rdy), 64'(vecs[i].exp_wr_rdy));
            checkOutput({nm, ".idle"},   64'(idle),       64'(vecs[i].exp_idle));
        end

        // Single load, data returns two cycles later, response one cycle after data.
        doReset();
        applyStimulus(1'b1, 1'b0, 4'd3, '0, '0);
        checkOutput("single.rd_rdy", 64'(rd_req_rdy), 64'd1);
        checkCommand("single", MEM_LOAD);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("single.vld_c1", 64'(rd_rsp_vld), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 4'd3, 64'hAB);
        checkOutput("single.vld_c2", 64'(rd_rsp_vld), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("single.vld_c3", 64'(rd_rsp_vld),  64'd1);
        checkOutput("single.data",   rd_rsp_data,      64'hAB);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("single.vld_c4", 64'(rd_rsp_vld), 64'd0);
        checkOutput("single.idle",   64'(idle),       64'd1);
        checkOutput("single.err",    64'(err_unmatched), 64'd0);

        // Both requesters always valid: LOAD, STORE, LOAD ... from reset.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, MEM_TAG'(i + 1), '0, '0);
            checkOutput($sformatf("alt%0d.cmd", i), 64'(proc2mem_command),
                        64'((i % 2 == 0) ? MEM_LOAD : MEM_STORE));
        end

        // Four loads returned out of order 4,2,1,3; fifth load waits for space.
        doReset();
        for (int t = 1; t <= 4; t++) begin
            applyStimulus(1'b1, 1'b0, MEM_TAG'(t), '0, '0);
            checkOutput($sformatf("ooo.alloc%0d", t), 64'(rd_req_rdy), 64'd1);
        end
        applyStimulus(1'b1, 1'b0, 4'd5, 4'd4, 64'h44);
        checkOutput("ooo.full_c4",  64'(rd_req_rdy), 64'd0);
        checkOutput("ooo.cmd_full", 64'(proc2mem_command), 64'(MEM_NONE));
        applyStimulus(1'b1, 1'b0, 4'd5, 4'd2, 64'h22);
        checkOutput("ooo.full_c5",  64'(rd_req_rdy), 64'd0);
        checkOutput("ooo.vld_c5",   64'(rd_rsp_vld), 64'd0);
        applyStimulus(1'b1, 1'b0, 4'd5, 4'd1, 64'h11);
        checkOutput("ooo.full_c6",  64'(rd_req_rdy), 64'd0);
        checkOutput("ooo.vld_c6",   64'(rd_rsp_vld), 64'd0);
        applyStimulus(1'b1, 1'b0, 4'd5, 4'd3, 64'h33);
        checkOutput("ooo.full_pop", 64'(rd_req_rdy), 64'd0);
        checkOutput("ooo.vld1",     64'(rd_rsp_vld), 64'd1);
        checkOutput("ooo.data1",    rd_rsp_data,     64'h11);
        applyStimulus(1'b1, 1'b0, 4'd5, '0, '0);
        checkOutput("ooo.alloc5",   64'(rd_req_rdy), 64'd1);
        checkOutput("ooo.vld2",     64'(rd_rsp_vld), 64'd1);
        checkOutput("ooo.data2",    rd_rsp_data,     64'h22);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("ooo.vld3",     64'(rd_rsp_vld), 64'd1);
        checkOutput("ooo.data3",    rd_rsp_data,     64'h33);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("ooo.vld4",     64'(rd_rsp_vld), 64'd1);
        checkOutput("ooo.data4",    rd_rsp_data,     64'h44);
        applyStimulus(1'b0, 1'b0, '0, 4'd5, 64'h55);
        checkOutput("ooo.head_wait", 64'(rd_rsp_vld), 64'd0);
        checkOutput("ooo.not_idle",  64'(idle),       64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("ooo.vld5",     64'(rd_rsp_vld), 64'd1);
        checkOutput("ooo.data5",    rd_rsp_data,     64'h55);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("ooo.idle",     64'(idle),          64'd1);
        checkOutput("ooo.err",      64'(err_unmatched), 64'd0);

        // Rejected commands leave last_grant alone; only the accepted one allocates.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, '0, '0, '0);
            checkOutput($sformatf("rej%0d.cmd", i),    64'(proc2mem_command), 64'(MEM_LOAD));
            checkOutput($sformatf("rej%0d.rd_rdy", i), 64'(rd_req_rdy),       64'd0);
            checkOutput($sformatf("rej%0d.wr_rdy", i), 64'(wr_req_rdy),       64'd0);
        end
        applyStimulus(1'b1, 1'b1, 4'd5, '0, '0);
        checkOutput("rej.accept_rd", 64'(rd_req_rdy), 64'd1);
        applyStimulus(1'b1, 1'b1, '0, '0, '0);
        checkOutput("rej.flip_cmd",  64'(proc2mem_command), 64'(MEM_STORE));
        applyStimulus(1'b0, 1'b0, '0, 4'd5, 64'h5A);
        checkOutput("rej.vld_wait",  64'(rd_rsp_vld), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("rej.vld",       64'(rd_rsp_vld), 64'd1);
        checkOutput("rej.data",      rd_rsp_data,     64'h5A);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("rej.one_entry", 64'(idle),       64'd1);

        // Unmatched data tag sets a sticky error and leaves the table empty.
        doReset();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("unm.err0", 64'(err_unmatched), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 4'd7, 64'h77);
        checkOutput("unm.err_same", 64'(err_unmatched), 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, '0);
            checkOutput($sformatf("unm.err_hold%0d", i), 64'(err_unmatched), 64'd1);
            checkOutput($sformatf("unm.idle%0d", i),     64'(idle),          64'd1);
            checkOutput($sformatf("unm.vld%0d", i),      64'(rd_rsp_vld),    64'd0);
        end
        doReset();
        #1;
        checkOutput("unm.err_clr", 64'(err_unmatched), 64'd0);

        // Reset with two loads outstanding drops them; late data is unmatched.
        doReset();
        applyStimulus(1'b1, 1'b0, 4'd1, '0, '0);
        checkOutput("rst2.alloc1", 64'(rd_req_rdy), 64'd1);
        applyStimulus(1'b1, 1'b0, 4'd2, '0, '0);
        checkOutput("rst2.alloc2", 64'(rd_req_rdy), 64'd1);
        applyStimulus(1'b1, 1'b0, 4'd3, '0, '0);
        rst = 1'b0;
        #1;
        checkOutput("rst2.cmd",    64'(proc2mem_command), 64'(MEM_NONE));
        checkOutput("rst2.rd_rdy", 64'(rd_req_rdy),       64'd0);
        checkOutput("rst2.vld",    64'(rd_rsp_vld),       64'd0);
        rd_req_vld = 1'b0;
        #1;
        checkOutput("rst2.idle",   64'(idle), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 4'd1, 64'h11);
        checkOutput("rst2.idle_after", 64'(idle),          64'd1);
        checkOutput("rst2.err_pre",    64'(err_unmatched), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 4'd2, 64'h22);
        checkOutput("rst2.err_set",    64'(err_unmatched), 64'd1);
        checkOutput("rst2.no_rsp1",    64'(rd_rsp_vld),    64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("rst2.no_rsp2",    64'(rd_rsp_vld),    64'd0);
        checkOutput("rst2.err_hold",   64'(err_unmatched), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
